// File: rtl/regfile_pkg.sv
// Shared constants for the register file: data width, index width and register count.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

endpackage : regfile_pkg

// File: rtl/regfile_decoder.sv
// Binary index to one-hot decode, gated by an enable; at most one output bit is set.
module regfile_decoder
    import regfile_pkg::*;
#(
    parameter int IDX_W = regfile_pkg::ADDR_W
) (
    input  logic                  en,
    input  logic [IDX_W-1:0]      idx,
    output logic [(2**IDX_W)-1:0] onehot
);

    always_comb begin
        // NOTE: default every bit before the indexed assignment so no latch is inferred.
        onehot      = '0;
        onehot[idx] = en;
    end

endmodule : regfile_decoder

// File: rtl/regfile.sv
// 32-entry register file: one write port, two combinational read ports, r0 hard-wired to zero.
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              ctrl_writeEnable,
    input  logic [ADDR_W-1:0] ctrl_writeReg,
    input  logic [DATA_W-1:0] data_writeReg,
    input  logic [ADDR_W-1:0] ctrl_readRegA,
    input  logic [ADDR_W-1:0] ctrl_readRegB,
    output logic [DATA_W-1:0] data_readRegA,
    output logic [DATA_W-1:0] data_readRegB
);

    localparam int REGS = 2 ** ADDR_W;

    logic [REGS-1:0]             we_onehot;
    logic [REGS-1:0]             sel_a;
    logic [REGS-1:0]             sel_b;
    logic [REGS-1:0][DATA_W-1:0] reg_q;

    regfile_decoder #(.IDX_W(ADDR_W)) u_dec_wr (
        .en     (ctrl_writeEnable),
        .idx    (ctrl_writeReg),
        .onehot (we_onehot)
    );

    regfile_decoder #(.IDX_W(ADDR_W)) u_dec_a (
        .en     (1'b1),
        .idx    (ctrl_readRegA),
        .onehot (sel_a)
    );

    regfile_decoder #(.IDX_W(ADDR_W)) u_dec_b (
        .en     (1'b1),
        .idx    (ctrl_readRegB),
        .onehot (sel_b)
    );

    // r0 is a constant; its write enable is decoded but intentionally dropped.
    logic unused_we0;
    assign unused_we0 = we_onehot[0];
    assign reg_q[0]   = '0;

    for (genvar i = 1; i < REGS; i++) begin : g_reg
        logic [DATA_W-1:0] q;

        // NOTE: every storage flop takes the async clear, since reset must zero reads without a clock.
        always_ff @(posedge clock or posedge ctrl_reset) begin
            if (ctrl_reset) begin
                // NOTE: non-blocking assignment keeps all banks updating from pre-edge values.
                q <= '0;
            end else if (we_onehot[i]) begin
                q <= data_writeReg;
            end
        end

        assign reg_q[i] = q;
    end

    // AND-OR read selection: one-hot select guarantees a single contributing source per bit.
    always_comb begin
        data_readRegA = '0;
        data_readRegB = '0;
        for (int i = 0; i < REGS; i++) begin
            data_readRegA |= reg_q[i] & {DATA_W{sel_a[i]}};
            data_readRegB |= reg_q[i] & {DATA_W{sel_b[i]}};
        end
    end

endmodule : regfile

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile: writes, r0 discard, no-bypass timing, sweep and async reset.
module tb_regfile;

    logic        clock;
    logic        ctrl_reset;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;

    logic [31:0] model [32];
    int          checks = 0;
    int          errors = 0;

    regfile dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Single write; the bench's model only tracks nonzero indices because r0 is constant.
    task automatic wr(input logic [4:0] idx, input logic [31:0] d);
        @(negedge clock);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = idx;
        data_writeReg    = d;
        @(posedge clock);
        #1;
        ctrl_writeEnable = 1'b0;
        if (idx != 5'd0) model[idx] = d;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [4:0] b);
        ctrl_readRegA = a;
        ctrl_readRegB = b;
        #1;
        check({tag, "_a"}, data_readRegA, model[a]);
        check({tag, "_b"}, data_readRegB, model[b]);
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd(tag, 5'(i), 5'(31 - i));
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        ctrl_reset       = 1'b1;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = '0;
        data_writeReg    = '0;
        ctrl_readRegA    = '0;
        ctrl_readRegB    = '0;
        repeat (2) @(posedge clock);
        #1;
        ctrl_readRegA = 5'd5;
        ctrl_readRegB = 5'd31;
        #1;
        check("rst_a", data_readRegA, 32'h0);
        check("rst_b", data_readRegB, 32'h0);
        @(negedge clock);
        ctrl_reset = 1'b0;

        // Same register on both ports after a plain write.
        wr(5'd5, 32'hDEADBEEF);
        ctrl_readRegA = 5'd5;
        ctrl_readRegB = 5'd5;
        #1;
        check("r5_a", data_readRegA, 32'hDEADBEEF);
        check("r5_b", data_readRegB, 32'hDEADBEEF);

        // Write to r0 is discarded and disturbs nothing else.
        wr(5'd0, 32'h12345678);
        ctrl_readRegA = 5'd0;
        #1;
        check("r0_zero", data_readRegA, 32'h0);
        sweep("after_r0");

        // No bypass: old value before the edge, new value after it.
        wr(5'd7, 32'h0000000A);
        @(negedge clock);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd7;
        data_writeReg    = 32'h0000000B;
        ctrl_readRegA    = 5'd7;
        #1;
        check("nobyp_pre", data_readRegA, 32'h0000000A);
        @(posedge clock);
        #1;
        ctrl_writeEnable = 1'b0;
        model[7] = 32'h0000000B;
        check("nobyp_post", data_readRegA, 32'h0000000B);

        // Every register holds its own index.
        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
        sweep("fill");

        // Write enable low: address/data toggling must not disturb contents.
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            ctrl_writeEnable = 1'b0;
            ctrl_writeReg    = 5'($urandom_range(0, 31));
            data_writeReg    = $urandom;
        end
        @(posedge clock);
        #1;
        sweep("hold");

        // Mid-cycle async reset clears without an edge; writes during reset are lost.
        wr(5'd3, 32'hFFFFFFFF);
        ctrl_readRegA = 5'd3;
        #1;
        check("r3_full", data_readRegA, 32'hFFFFFFFF);
        #1;
        ctrl_reset = 1'b1;
        #1;
        check("rst_async", data_readRegA, 32'h0);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd9;
        data_writeReg    = 32'h00000055;
        ctrl_readRegB    = 5'd9;
        @(posedge clock);
        #1;
        check("rst_wr_b", data_readRegB, 32'h0);
        @(negedge clock);
        ctrl_writeEnable = 1'b0;
        ctrl_reset       = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        #1;
        sweep("post_rst");

        // First write after release lands on the first rising edge.
        wr(5'd9, 32'h00000077);
        rd("first_wr", 5'd9, 5'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_regfile
